// File: rtl/tick_divider_channel.sv
// One divider channel: free-running period counter with shadowed period/high config.
// Pending config is promoted to active only at a period boundary, a disable or a sync restart.
module tick_divider_channel #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_high,
  output logic             o_tick,
  output logic             o_wave
);

  localparam logic [WIDTH-1:0] DEF_P      = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH:0]   DEF_H_FULL = ({1'b0, DEF_P} + 1'b1) >> 1;
  localparam logic [WIDTH-1:0] DEF_H      = DEF_H_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_p_act;
  logic [WIDTH-1:0] r_h_act;
  logic [WIDTH-1:0] r_p_pend;
  logic [WIDTH-1:0] r_h_pend;
  logic             r_pend_vld;
  logic             r_tick;
  logic             r_wave;

  logic [WIDTH-1:0] w_p_pend;
  logic [WIDTH-1:0] w_h_pend;
  logic             w_vld;
  logic             w_apply;
  logic [WIDTH-1:0] w_cnt_use;
  logic [WIDTH-1:0] w_p_use;
  logic [WIDTH-1:0] w_h_use;
  logic             w_tick_nxt;
  logic             w_wave_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;

  // A write landing on the apply edge must be the value that gets applied.
  assign w_p_pend = i_we ? i_period : r_p_pend;
  assign w_h_pend = i_we ? i_high   : r_h_pend;
  assign w_vld    = i_we | r_pend_vld;
  assign w_apply  = w_vld & (~i_en | i_sync | (r_cnt == r_p_act));

  // A sync edge restarts from cnt=0 using the config applied on that same edge.
  always_comb begin
    w_cnt_use = r_cnt;
    w_p_use   = r_p_act;
    w_h_use   = r_h_act;
    if (i_sync) begin
      w_cnt_use = '0;
      if (w_vld) begin
        w_p_use = w_p_pend;
        w_h_use = w_h_pend;
      end
    end
    w_tick_nxt = (w_cnt_use == w_p_use);
    w_wave_nxt = (w_cnt_use < w_h_use);
    w_cnt_nxt  = w_tick_nxt ? '0 : w_cnt_use + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_p_act    <= DEF_P;
      r_h_act    <= DEF_H;
      r_p_pend   <= DEF_P;
      r_h_pend   <= DEF_H;
      r_pend_vld <= 1'b0;
      r_tick     <= 1'b0;
      r_wave     <= 1'b0;
    end else begin
      r_p_pend <= w_p_pend;
      r_h_pend <= w_h_pend;
      if (w_apply) begin
        r_p_act    <= w_p_pend;
        r_h_act    <= w_h_pend;
        r_pend_vld <= 1'b0;
      end else if (i_we) begin
        r_pend_vld <= 1'b1;
      end
      if (!i_en) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_wave <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_tick <= w_tick_nxt;
        r_wave <= w_wave_nxt;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_wave = r_wave;

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of independent programmable tick/wave dividers for the display/IO fabric.
// Decodes the config port into per-channel write strobes and fans out sync_all.
module tick_divider_bank #(
  parameter  int CHANNELS    = 4,
  parameter  int WIDTH       = 16,
  parameter  int DEFAULT_DIV = 1,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync_all,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_high,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] wave
);

  logic [CHANNELS-1:0] w_we;

  // Addresses at or above CHANNELS match no channel, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_we[i] = cfg_we & (cfg_ch == CH_W'(i));

    tick_divider_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (ch_en[i]),
      .i_sync  (sync_all),
      .i_we    (w_we[i]),
      .i_period(cfg_period),
      .i_high  (cfg_high),
      .o_tick  (tick[i]),
      .o_wave  (wave[i])
    );
  end

endmodule
